// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the bit slice consumed by serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder slice driven LSB first, with the carry kept
// in a register between cycles and a start/ready/done handshake.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, shb_q, shs_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q;
    logic             fa_sum, fa_cout;
    logic             accept, last;

    full_adder u_fa (
        .a    (sha_q[0]),
        .b    (shb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept = ready & start;
    assign last   = (state_q == ST_SHIFT) && (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_SHIFT: busy  = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at LSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            sha_q   <= a;
            shb_q   <= b;
            shs_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == ST_SHIFT) begin
            sha_q   <= {1'b0, sha_q[WIDTH-1:1]};
            shb_q   <= {1'b0, shb_q[WIDTH-1:1]};
            shs_q   <= {fa_sum, shs_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CntW'(1);
            if (last) begin
                sum_q  <= {fa_sum, shs_q[WIDTH-1:1]};
                cout_q <= fa_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         ready, busy, done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs [8];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Start accepted at the edge ending cycle 0; start dropped at cycle 1.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        cin   = ~cv;
        check("busy_c1", 32'(busy), 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        launch(v.a, v.b, v.cin);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            check("busy_window", 32'(busy), 32'd1);
            check("no_early_done", 32'(done), 32'd0);
            check("sum_stable", 32'(sum), 32'(prev_sum));
        end
        @(negedge clk);
        check("done_c9", 32'(done), 32'd1);
        check("busy_c9", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(v.s));
        check("cout", 32'(cout), 32'(v.c));
        @(negedge clk);
        check("done_pulse_one", 32'(done), 32'd0);
        prev_sum  = v.s;
        prev_cout = v.c;
    endtask

    initial begin
        logic [W:0]   ref_r;
        logic [W-1:0] cur_a, cur_b, nxt_a, nxt_b;
        logic         cur_c, nxt_c;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, s: 8'h96, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
        vecs[3] = '{a: 8'h01, b: 8'h01, cin: 1'b0, s: 8'h02, c: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1};
        vecs[6] = '{a: 8'h0F, b: 8'hF0, cin: 1'b1, s: 8'h00, c: 1'b1};
        vecs[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, s: 8'hFF, c: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // start pulsed mid-operation must be ignored
        launch(8'h12, 8'h34, 1'b0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("ready_low_in_shift", 32'(ready), 32'd0);
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'hAA;
            end else begin
                start = 1'b0;
            end
        end
        check("ign_done", 32'(done), 32'd1);
        check("ign_sum", 32'(sum), 32'h46);
        check("ign_cout", 32'(cout), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_sum_hold", 32'(sum), 32'h46);
            check("idle_no_done", 32'(done), 32'd0);
            check("idle_not_busy", 32'(busy), 32'd0);
        end

        // reset in the middle of an operation
        launch(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        rst_n     = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        run_op('{a: 8'h01, b: 8'h01, cin: 1'b0, s: 8'h02, c: 1'b0});

        // start held high: back-to-back accepts every 9 cycles, random operands
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        cur_c = 1'($urandom);
        @(negedge clk);
        start = 1'b1;
        a     = cur_a;
        b     = cur_b;
        cin   = cur_c;
        for (int i = 0; i < 1000; i++) begin
            nxt_a = 8'($urandom);
            nxt_b = 8'($urandom);
            nxt_c = 1'($urandom);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                if (k <= 8) begin
                    check("b2b_busy", 32'(busy), 32'd1);
                    check("b2b_no_done", 32'(done), 32'd0);
                end
                if (k == 2) begin
                    a   = 8'($urandom);
                    b   = 8'($urandom);
                    cin = 1'($urandom);
                end
                if (k == 5) begin
                    check("b2b_sum_stable", 32'(sum), 32'(prev_sum));
                    a   = nxt_a;
                    b   = nxt_b;
                    cin = nxt_c;
                end
            end
            ref_r = {1'b0, cur_a} + {1'b0, cur_b} + {{W{1'b0}}, cur_c};
            check("b2b_done", 32'(done), 32'd1);
            check("b2b_sum", 32'(sum), 32'(ref_r[W-1:0]));
            check("b2b_cout", 32'(cout), 32'(ref_r[W]));
            prev_sum = ref_r[W-1:0];
            cur_a    = nxt_a;
            cur_b    = nxt_b;
            cur_c    = nxt_c;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("final_idle_ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
